spm_ctrl: RTL and testbench
===========================

# spm_ctrl

Sequencer for the serial/parallel multiplier `spm`. It accepts a pair of signed operands over a valid/ready handshake and clears the multiplier. It then streams the multiplier operand LSB-first, sign-extended, into the serial input, and reassembles the serial product into a 2·SIZE-bit word. The result is returned over a second valid/ready handshake. It sits between the bus-side operand registers and one `spm` instance, owning that instance's reset, parallel and serial inputs.

## Interface
- SIZE, 32, operand width N; must match the attached `spm` size; N ≥ 4
- CW, $clog2(2*SIZE)+1, width of the bit counter
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- in_x  in  SIZE  parallel multiplicand, two's complement
- in_y  in  SIZE  multiplier, two's complement
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_p  out  2·SIZE  signed product x·y
- busy  out  1  high in any state other than IDLE
- spm_rst  out  1  registered clear to `spm`
- spm_x  out  SIZE  parallel operand to `spm`
- spm_y  out  1  serial operand to `spm`
- spm_p  in  1  serial product from `spm`
- op_count  out  32  completed-operation counter; present only with SPM_CTRL_PERF_EN

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: latch x into spm_x and y into y_reg, then go to CLEAR.
- CLEAR
  - spm_rst=1 for exactly one cycle, cnt←0, then go to RUN.
- RUN
  - Lasts 2N cycles, cnt=0..2N−1.
  - spm_y = y_reg[cnt] for cnt<N, else y_reg[N−1] (sign extension).
  - From cnt≥1, shift spm_p into the MSB of a 2N-bit shift register (right shift); this captures product bits 0..2N−2.
  - After cnt=2N−1, go to DRAIN.
- DRAIN
  - spm_y=0. Capture the final bit 2N−1, then go to DONE.
- DONE
  - out_valid=1 and out_p is stable.
  - On out_ready: go to IDLE and increment op_count.
- Arithmetic:
  - out_p is the exact two's-complement product, truncated to 2N bits. No overflow is possible.
  - −2^(N−1)·−2^(N−1) = 2^(2N−2) fits.
- spm_x is held constant from the cycle after acceptance until the return to IDLE.
- in_valid outside IDLE is ignored; in_ready=0 in those states.
- No overlap between operations: a new accept is possible only in the IDLE cycle after the DONE handshake.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_p=0, busy=0.
  - spm_rst=1 (holds `spm` cleared during reset; drops in the first cycle after deassertion), spm_x=0, spm_y=0, op_count=0.
- Acceptance at edge T:
  - CLEAR during cycle T+1.
  - RUN during cycles T+2 .. T+2N+1.
  - DRAIN at T+2N+2.
  - out_valid is high from T+2N+3.
  - Accept-to-valid latency is 2N+3 cycles.
- out_valid stays high with out_p unchanged for as long as out_ready=0.
- All outputs are registered; spm_rst is glitch-free.
- If rst asserts mid-operation, the operation is aborted immediately: in-flight data is discarded, out_valid=0, and op_count does not increment.

## Configuration
- SPM_CTRL_PERF_EN
  - Defined: a 32-bit op_count port and register exist; it increments on each out_valid&out_ready and wraps 0xFFFFFFFF→0.
  - Undefined: the port and register are absent; all other behaviour is identical.

## Structure
- Shared package spm_pkg holds:
  - the state enum spm_ctrl_state_t (IDLE, CLEAR, RUN, DRAIN, DONE)
  - the default SPM_SIZE=32
- One sub-module, spm_shreg: a 2N-bit serial-in right shift register with capture-enable. It is used for product reassembly.
- The y bit selection stays inline.
- `spm` itself is instantiated by the parent, not inside spm_ctrl.

## Test plan
All scenarios use N=8, with `spm` attached.
- Basic product: x=3, y=5 → out_p=0x000F, out_valid at accept+19.
- Both negative: x=−1 (0xFF), y=−1 (0xFF) → out_p=0x0001.
- Mixed sign at the range extremes:
  - x=−128 (0x80), y=127 (0x7F) → out_p=0xC080.
  - x=−128, y=−128 → out_p=0x4000.
- Backpressure: hold out_ready=0 for 10 cycles after valid → out_valid and out_p remain stable, in_ready=0, busy=1. On release, the next op (x=2, y=−3) → 0xFFFA.
- Busy input: assert in_valid with new operands during RUN → ignored, and the first result is unaffected.
- Reset mid-operation: assert rst at RUN cnt=5 → out_valid=0, in_ready=1 after release, spm_rst high during reset. A following x=7, y=9 → 0x003F. With SPM_CTRL_PERF_EN, op_count counts only completed handshakes.

Source files
------------

// File: rtl/spm_pkg.sv
// spm_pkg: shared types and defaults for the spm serial/parallel multiplier and its sequencer.
package spm_pkg;
    localparam int SPM_SIZE = 32;
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} spm_ctrl_state_t;
endpackage

// File: rtl/spm_shreg.sv
// spm_shreg: serial-in right shift register with capture enable; new bits enter at the MSB.
module spm_shreg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else if (en_i) q_q <= {d_i, q_q[W-1:1]};
    end
    assign q_o = q_q;
endmodule

// File: rtl/spm_ctrl.sv
// spm_ctrl: sequences one spm instance: clear, stream y LSB-first sign-extended, reassemble the product.
// SPM_CTRL_PERF_EN adds a 32-bit completed-operation counter port op_count.
module spm_ctrl
    import spm_pkg::*;
#(
    parameter int SIZE = SPM_SIZE,
    parameter int CW   = $clog2(2*SIZE)+1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_x,
    input  logic [SIZE-1:0]   in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] out_p,
    output logic              busy,
    output logic              spm_rst,
    output logic [SIZE-1:0]   spm_x,
    output logic              spm_y,
    input  logic              spm_p
`ifdef SPM_CTRL_PERF_EN
    ,
    output logic [31:0]       op_count
`endif
);
    localparam int IW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(2*SIZE-1);
    localparam logic [CW-1:0] NB   = CW'(SIZE);
    spm_ctrl_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] x_q, x_d, y_q, y_d;
    logic            spm_rst_q, spm_rst_d, spm_y_q, spm_y_d;
    logic            in_ready_q, out_valid_q, busy_q, shift_en;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE:  if (in_valid) begin
                       state_d = CLEAR;
                       x_d     = in_x;
                       y_d     = in_y;
                   end
            CLEAR: begin
                       state_d = RUN;
                       cnt_d   = '0;
                   end
            RUN:   begin
                       state_d = (cnt_q == LAST) ? DRAIN : RUN;
                       cnt_d   = cnt_q + CW'(1);
                   end
            DRAIN: state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        spm_rst_d = (state_q == IDLE) && in_valid;
        // y is presented one cycle ahead of use because spm_y is registered
        spm_y_d   = (state_d == RUN) && ((cnt_d < NB) ? y_q[cnt_d[IW-1:0]] : y_q[SIZE-1]);
        // spm_p lags spm_y by one cycle, so bit 0 arrives at cnt=1 and the last bit in DRAIN
        shift_en  = ((state_q == RUN) && (cnt_q != '0)) || (state_q == DRAIN);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            spm_rst_q   <= 1'b1;
            spm_y_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            spm_rst_q   <= spm_rst_d;
            spm_y_q     <= spm_y_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end
    spm_shreg #(.W(2*SIZE)) u_shreg (
        .clk (clk),
        .rst (rst),
        .en_i(shift_en),
        .d_i (spm_p),
        .q_o (out_p)
    );
`ifdef SPM_CTRL_PERF_EN
    logic [31:0] op_count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) op_count_q <= '0;
        else if (out_valid_q && out_ready) op_count_q <= op_count_q + 32'd1;
    end
    assign op_count = op_count_q;
`endif
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign spm_rst   = spm_rst_q;
    assign spm_x     = x_q;
    assign spm_y     = spm_y_q;
endmodule

// File: tb/tb_spm_ctrl.sv
// tb_spm_ctrl: directed bench for spm_ctrl (N=8) with a behavioural serial/parallel multiplier attached.
module tb_spm_ctrl;
    localparam int N = 8;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_x = '0, in_y = '0;
    logic        in_ready, out_valid, busy, spm_rst, spm_y, spm_p;
    logic [7:0]  spm_x;
    logic [15:0] out_p;
`ifdef SPM_CTRL_PERF_EN
    logic [31:0] op_count;
`endif
    int checks = 0, errors = 0, exp_ops = 0;
    logic [15:0] m_y;
    logic [4:0]  m_k;

    spm_ctrl #(.SIZE(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .busy(busy), .spm_rst(spm_rst), .spm_x(spm_x),
        .spm_y(spm_y), .spm_p(spm_p)
`ifdef SPM_CTRL_PERF_EN
        , .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    // spm model: after consuming y bit k it presents product bit k on the next cycle
    function automatic logic pbit(input logic [7:0] x, input logic [15:0] y, input logic [4:0] k);
        logic [15:0] p;
        p = {{8{x[7]}}, x} * y;
        return p[k[3:0]];
    endfunction

    always @(posedge clk) begin
        if (spm_rst) begin
            m_k <= '0; m_y <= '0; spm_p <= 1'b0;
        end else if (m_k < 5'd16) begin
            spm_p <= pbit(spm_x, m_y | ({15'd0, spm_y} << m_k), m_k);
            m_y   <= m_y | ({15'd0, spm_y} << m_k);
            m_k   <= m_k + 5'd1;
        end else begin
            spm_p <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp_p,
                          input int hold, input bit inject, input string tag);
        int n, cyc;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk({tag, "_ready"}, in_ready, 1);
        in_x = x; in_y = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 100) begin
            if (inject) begin
                in_valid = (cyc >= 3 && cyc <= 9);
                in_x = 8'hAA; in_y = 8'h55;
            end
            tick();
            cyc++;
            if (inject && cyc == 6) begin
                chk({tag, "_busy_ready"}, in_ready, 0);
                chk({tag, "_busy_x"}, spm_x, x);
                chk({tag, "_busy_busy"}, busy, 1);
            end
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, cyc, 19);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_p"}, out_p, exp_p);
            chk({tag, "_hold_ready"}, in_ready, 0);
            chk({tag, "_hold_busy"}, busy, 1);
            tick();
        end
        chk(tag, out_p, exp_p);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_ops++;
        chk({tag, "_post_valid"}, out_valid, 0);
        chk({tag, "_post_ready"}, in_ready, 1);
        chk({tag, "_post_busy"}, busy, 0);
`ifdef SPM_CTRL_PERF_EN
        chk({tag, "_op_count"}, op_count, exp_ops);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spm_rst", spm_rst, 1);
        chk("rst_spm_x", spm_x, 0);
        chk("rst_spm_y", spm_y, 0);
`ifdef SPM_CTRL_PERF_EN
        chk("rst_op_count", op_count, 0);
`endif
        rst = 1'b0;
        tick();
        chk("rel_spm_rst", spm_rst, 0);
        chk("rel_in_ready", in_ready, 1);

        run_op(8'd3,  8'd5,  16'h000F, 0, 1'b0, "basic");
        run_op(8'hFF, 8'hFF, 16'h0001, 0, 1'b0, "neg_neg");
        run_op(8'h80, 8'h7F, 16'hC080, 0, 1'b0, "min_max");
        run_op(8'h80, 8'h80, 16'h4000, 0, 1'b0, "min_min");
        run_op(8'd12, 8'd10, 16'h0078, 10, 1'b0, "backpressure");
        run_op(8'd2,  8'hFD, 16'hFFFA, 0, 1'b0, "after_bp");
        run_op(8'd17, 8'd5,  16'h0055, 0, 1'b1, "busy_in");

        in_x = 8'd5; in_y = 8'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("midop_busy", busy, 1);
        rst = 1'b1;
        exp_ops = 0;
        #1;
        chk("midop_out_valid", out_valid, 0);
        chk("midop_in_ready", in_ready, 1);
        chk("midop_spm_rst", spm_rst, 1);
        chk("midop_busy_rst", busy, 0);
        chk("midop_out_p", out_p, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("midop_rel_in_ready", in_ready, 1);
        chk("midop_rel_out_valid", out_valid, 0);
        chk("midop_rel_spm_rst", spm_rst, 0);
`ifdef SPM_CTRL_PERF_EN
        chk("midop_op_count", op_count, 0);
`endif
        run_op(8'd7, 8'd9, 16'h003F, 0, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
